// File: rtl/data_out_reg_if.sv
// ---------------------------------------------------------------------------
// data_out_reg_if
// Groups the command, SDRAM DQ, host read-data and status signals of the
// SDRAM read-data return path.
//   slave  modport : used by data_out_reg (commands/data in, status out)
//   master modport : used by whoever drives commands and drains read data
// Signals:
//   rd_cmd, cas_lat, burst_len  READ command pulse, CAS latency, burst code
//   dq_in                       SDRAM DQ read data
//   host_rdy, ovf_clr           host accept strobe, sticky-overflow clear
//   dataout, dataout_valid      FIFO head word and its valid flag
//   fifo_lvl                    words held in the FIFO (0..FIFO_DEPTH)
//   busy, burst_done, cmd_err   read in progress, last-beat pulse, reject pulse
//   ovf                         sticky overflow flag
//   state_dbg                   current FSM state, for debug/checkers
//   dataout_par                 per-byte even parity of dataout (only when
//                               DATA_OUT_PARITY_EN is defined)
// Handshake: a word moves from the FIFO to the host on every clk0 edge where
// dataout_valid && host_rdy; dataout_valid never depends on host_rdy.
// ---------------------------------------------------------------------------
interface data_out_reg_if #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                   rd_cmd;
    logic [1:0]             cas_lat;
    logic [1:0]             burst_len;
    logic [DATA_SIZE-1:0]   dq_in;
    logic                   host_rdy;
    logic                   ovf_clr;
    logic [DATA_SIZE-1:0]   dataout;
    logic                   dataout_valid;
    logic [LVL_W-1:0]       fifo_lvl;
    logic                   busy;
    logic                   burst_done;
    logic                   cmd_err;
    logic                   ovf;
    logic [1:0]             state_dbg;
`ifdef DATA_OUT_PARITY_EN
    logic [DATA_SIZE/8-1:0] dataout_par;
`endif

    modport slave (
        input  rd_cmd, cas_lat, burst_len, dq_in, host_rdy, ovf_clr,
        output dataout, dataout_valid, fifo_lvl, busy, burst_done, cmd_err,
`ifdef DATA_OUT_PARITY_EN
        output dataout_par,
`endif
        output ovf, state_dbg
    );

    modport master (
        output rd_cmd, cas_lat, burst_len, dq_in, host_rdy, ovf_clr,
        input  dataout, dataout_valid, fifo_lvl, busy, burst_done, cmd_err,
`ifdef DATA_OUT_PARITY_EN
        input  dataout_par,
`endif
        input  ovf, state_dbg
    );
endinterface

// File: rtl/data_out_reg.sv
// ---------------------------------------------------------------------------
// data_out_reg
// SDRAM controller read-data return path. After a READ command it times the
// CAS-latency window, captures the burst from the SDRAM DQ bus and buffers it
// in a first-word-fall-through FIFO that the host drains with valid/ready.
// Ports:
//   clk0   system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    data_out_reg_if.slave (command, DQ, host read data, status)
// Optional feature: define DATA_OUT_PARITY_EN to add bus.dataout_par, the
// per-byte even parity of dataout, computed on push and stored per entry.
// ---------------------------------------------------------------------------
module data_out_reg #(
    parameter int DATA_SIZE  = 32,
    parameter int DQM_SIZE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk0,
    input  logic          reset,
    data_out_reg_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_CL = 2'd1;
    localparam logic [1:0] S_BURST   = 2'd2;

    if (DQM_SIZE * 8 != DATA_SIZE) begin : g_bad_dqm
        $error("DQM_SIZE must equal DATA_SIZE/8");
    end

    // FSM and burst timing
    logic [1:0]           state_q, state_d;
    logic                 cnt_q, cnt_d;       // remaining CL wait (CL-2)
    logic [2:0]           bl_m1_q, bl_m1_d;   // burst length minus one
    logic [2:0]           bcnt_q, bcnt_d;     // beats left after this one
    logic                 burst_done_q, burst_done_d;
    logic                 cmd_err_q, cmd_err_d;

    // Capture stage: one beat in flight between DQ sample and FIFO push
    logic [DATA_SIZE-1:0] dq_q, dq_d;
    logic                 cap_q, cap_d;

    // FIFO
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop, full, drop;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bl_m1_d      = bl_m1_q;
        bcnt_d       = bcnt_q;
        burst_done_d = 1'b0;
        cap_d        = 1'b0;
        dq_d         = dq_q;
        // Only one read may be outstanding; anything else is rejected.
        cmd_err_d    = bus.rd_cmd && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.rd_cmd) begin
                    state_d = S_WAIT_CL;
                    // CL 0/1 are treated as 2, so only CL3 needs an extra cycle.
                    cnt_d   = (bus.cas_lat == 2'd3);
                    case (bus.burst_len)
                        2'd0:    bl_m1_d = 3'd0;
                        2'd1:    bl_m1_d = 3'd1;
                        2'd2:    bl_m1_d = 3'd3;
                        default: bl_m1_d = 3'd7;
                    endcase
                end
            end
            S_WAIT_CL: begin
                if (cnt_q == 1'b0) begin
                    state_d = S_BURST;
                    bcnt_d  = bl_m1_q;
                end else begin
                    cnt_d = 1'b0;
                end
            end
            S_BURST: begin
                dq_d  = bus.dq_in;
                cap_d = 1'b1;
                if (bcnt_q == 3'd0) begin
                    state_d      = S_IDLE;
                    burst_done_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign full = (lvl_q == LW'(FIFO_DEPTH));
    assign pop  = (lvl_q != '0) && bus.host_rdy;
    assign push = cap_q && (!full || pop);
    assign drop = cap_q && full && !pop;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = dq_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
        // A new drop wins over a simultaneous clear.
        ovf_d = bus.ovf_clr ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 1'b0;
            bl_m1_q      <= 3'd0;
            bcnt_q       <= 3'd0;
            burst_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            dq_q         <= '0;
            cap_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lvl_q        <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bl_m1_q      <= bl_m1_d;
            bcnt_q       <= bcnt_d;
            burst_done_q <= burst_done_d;
            cmd_err_q    <= cmd_err_d;
            dq_q         <= dq_d;
            cap_q        <= cap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lvl_q        <= lvl_d;
            ovf_q        <= ovf_d;
            mem_q        <= mem_d;
        end
    end

`ifdef DATA_OUT_PARITY_EN
    // Even parity: the parity bit makes each byte plus its bit an even count.
    logic [DQM_SIZE-1:0] par_mem_q [FIFO_DEPTH];
    logic [DQM_SIZE-1:0] par_mem_d [FIFO_DEPTH];
    logic [DQM_SIZE-1:0] push_par;

    always_comb begin
        for (int b = 0; b < DQM_SIZE; b++) push_par[b] = ^dq_q[b*8 +: 8];
        par_mem_d = par_mem_q;
        if (push) par_mem_d[wr_ptr_q] = push_par;
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) par_mem_q[i] <= '0;
        end else begin
            par_mem_q <= par_mem_d;
        end
    end

    assign bus.dataout_par = par_mem_q[rd_ptr_q];
`endif

    assign bus.dataout       = mem_q[rd_ptr_q];
    assign bus.dataout_valid = (lvl_q != '0);
    assign bus.fifo_lvl      = lvl_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.burst_done    = burst_done_q;
    assign bus.cmd_err       = cmd_err_q;
    assign bus.ovf           = ovf_q;
    assign bus.state_dbg     = state_q;
endmodule
